// File: rtl/tick_stopwatch.sv
// tick_stopwatch: mm:ss BCD stopwatch advanced by upstream one-second ticks.
// A start/stop button edge toggles run/pause; clear returns to idle at 00:00.
//
// state | meaning
// IDLE  | cleared at 00:00, waiting for a start press
// RUN   | counting ticks
// PAUSE | digits frozen, waiting for a press to resume
// DONE  | saturated at 59:59 (HOLD_AT_MAX=1 only); only clear or reset exit

module tick_stopwatch #(
    parameter bit HOLD_AT_MAX = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       done,
    output logic       wrap
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_ss_prev;
    logic [3:0] r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
    logic [3:0] w_sec_ones_nxt, w_sec_tens_nxt, w_min_ones_nxt, w_min_tens_nxt;
    logic       r_running, r_done, r_wrap;
    logic       w_wrap_nxt;
    logic       w_edge;
    logic       w_at_max;
    logic [4:0] w_so_inc, w_st_inc, w_mo_inc, w_mt_inc;

    // One BCD digit stage: {carry_out, next_digit}. Using >= keeps any
    // out-of-range code from sticking; it simply rolls to 0.
    function automatic logic [4:0] bcd_step(
        input logic [3:0] d,
        input logic [3:0] lim,
        input logic       cin
    );
        logic [4:0] res;
        if (!cin)
            res = {1'b0, d};
        else if (d >= lim)
            res = {1'b1, 4'd0};
        else
            res = {1'b0, d + 4'd1};
        return res;
    endfunction

    assign w_edge   = start_stop & ~r_ss_prev;

    assign w_so_inc = bcd_step(r_sec_ones, 4'd9, 1'b1);
    assign w_st_inc = bcd_step(r_sec_tens, 4'd5, w_so_inc[4]);
    assign w_mo_inc = bcd_step(r_min_ones, 4'd9, w_st_inc[4]);
    assign w_mt_inc = bcd_step(r_min_tens, 4'd5, w_mo_inc[4]);

    // Carry out of the top digit means the current time is 59:59.
    assign w_at_max = w_mt_inc[4];

    always_comb begin
        w_state_nxt    = r_state;
        w_sec_ones_nxt = r_sec_ones;
        w_sec_tens_nxt = r_sec_tens;
        w_min_ones_nxt = r_min_ones;
        w_min_tens_nxt = r_min_tens;
        w_wrap_nxt     = 1'b0;

        if (clear) begin
            w_state_nxt    = ST_IDLE;
            w_sec_ones_nxt = 4'd0;
            w_sec_tens_nxt = 4'd0;
            w_min_ones_nxt = 4'd0;
            w_min_tens_nxt = 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_sec_ones_nxt = 4'd0;
                    w_sec_tens_nxt = 4'd0;
                    w_min_ones_nxt = 4'd0;
                    w_min_tens_nxt = 4'd0;
                    if (w_edge)
                        w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (tick && w_at_max && HOLD_AT_MAX) begin
                        // Saturation wins over a simultaneous button edge.
                        w_state_nxt = ST_DONE;
                    end else begin
                        if (tick) begin
                            w_sec_ones_nxt = w_so_inc[3:0];
                            w_sec_tens_nxt = w_st_inc[3:0];
                            w_min_ones_nxt = w_mo_inc[3:0];
                            w_min_tens_nxt = w_mt_inc[3:0];
                            w_wrap_nxt     = w_at_max;
                        end
                        if (w_edge)
                            w_state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (w_edge)
                        w_state_nxt = ST_RUN;
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_sec_ones_nxt = 4'd0;
                    w_sec_tens_nxt = 4'd0;
                    w_min_ones_nxt = 4'd0;
                    w_min_tens_nxt = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_ss_prev  <= 1'b1;
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_min_tens <= 4'd0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ss_prev  <= start_stop;
            r_sec_ones <= w_sec_ones_nxt;
            r_sec_tens <= w_sec_tens_nxt;
            r_min_ones <= w_min_ones_nxt;
            r_min_tens <= w_min_tens_nxt;
            r_running  <= (w_state_nxt == ST_RUN);
            r_done     <= (w_state_nxt == ST_DONE);
            r_wrap     <= w_wrap_nxt;
        end
    end

    assign sec_ones = r_sec_ones;
    assign sec_tens = r_sec_tens;
    assign min_ones = r_min_ones;
    assign min_tens = r_min_tens;
    assign running  = r_running;
    assign done     = r_done;
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_tick_stopwatch.sv
// Bench for tick_stopwatch: a hold instance and a wrap instance share stimulus
// and are compared every cycle against a seconds-count reference model.

module tb_tick_stopwatch;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tick = 1'b0;
    logic start_stop = 1'b0;
    logic clear = 1'b0;

    logic [3:0] h_so, h_st, h_mo, h_mt;
    logic       h_run, h_done, h_wrap;
    logic [3:0] w_so, w_st, w_mo, w_mt;
    logic       w_run, w_done, w_wrap;
    logic [37:0] obs;

    int total = 0;
    int bad = 0;

    // Reference model: index 0 = hold instance, 1 = wrap instance.
    int m_secs[2];
    int m_state[2];
    bit m_wrap[2];
    bit m_prev;

    tick_stopwatch #(.HOLD_AT_MAX(1'b1)) u_hold (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start_stop(start_stop), .clear(clear),
        .sec_ones(h_so), .sec_tens(h_st), .min_ones(h_mo), .min_tens(h_mt),
        .running(h_run), .done(h_done), .wrap(h_wrap)
    );

    tick_stopwatch #(.HOLD_AT_MAX(1'b0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start_stop(start_stop), .clear(clear),
        .sec_ones(w_so), .sec_tens(w_st), .min_ones(w_mo), .min_tens(w_mt),
        .running(w_run), .done(w_done), .wrap(w_wrap)
    );

    assign obs = {h_mt, h_mo, h_st, h_so, h_run, h_done, h_wrap,
                  w_mt, w_mo, w_st, w_so, w_run, w_done, w_wrap};

    initial forever #5 clk = ~clk;

    function automatic logic [18:0] exp_vec(int secs, int st, bit wr);
        logic [3:0] mt, mo, stn, so;
        mt  = 4'(secs / 600);
        mo  = 4'((secs / 60) % 10);
        stn = 4'((secs % 60) / 10);
        so  = 4'(secs % 10);
        return {mt, mo, stn, so, st == M_RUN, st == M_DONE, wr};
    endfunction

    function automatic logic [37:0] exp_all();
        return {exp_vec(m_secs[0], m_state[0], m_wrap[0]),
                exp_vec(m_secs[1], m_state[1], m_wrap[1])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_secs[i]  = 0;
            m_state[i] = M_IDLE;
            m_wrap[i]  = 1'b0;
        end
        m_prev = 1'b1;
    endtask

    task automatic model_update(bit tk, bit ss, bit clr);
        bit e;
        bit sat;
        e = ss && !m_prev;
        m_prev = ss;
        for (int i = 0; i < 2; i++) begin
            m_wrap[i] = 1'b0;
            if (clr) begin
                m_state[i] = M_IDLE;
                m_secs[i]  = 0;
            end else if (m_state[i] == M_IDLE || m_state[i] == M_PAUSE) begin
                if (e) m_state[i] = M_RUN;
            end else if (m_state[i] == M_RUN) begin
                sat = 1'b0;
                if (tk) begin
                    if (m_secs[i] == 3599 && i == 0) begin
                        sat = 1'b1;
                        m_state[i] = M_DONE;
                    end else begin
                        m_wrap[i] = (m_secs[i] == 3599);
                        m_secs[i] = (m_secs[i] + 1) % 3600;
                    end
                end
                if (e && !sat) m_state[i] = M_PAUSE;
            end
        end
    endtask

    task automatic step(bit tk, bit ss, bit clr);
        tick = tk;
        start_stop = ss;
        clear = clr;
        @(posedge clk);
        model_update(tk, ss, clr);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick = 1'b0; start_stop = 1'b0; clear = 1'b0;
        model_reset();
        #2;
        if (obs !== 38'd0) begin
            bad++; $display("FAIL reset_state got=%h exp=%h", obs, 38'd0);
        end
        total++;
        #10;
        reset_n = 1'b1;
        repeat (3) begin
            step(1'b1, 1'b0, 1'b0);
            if (obs !== exp_all()) begin
                bad++; $display("FAIL reset_idle t=%0t got=%h exp=%h", $time, obs, exp_all());
            end
            total++;
        end
    endtask

    task automatic test_count_75();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 75; n++) begin
            for (int c = 0; c < 4; c++) begin
                step(c == 0, 1'b0, 1'b0);
                if (obs !== exp_all()) begin
                    bad++; $display("FAIL count75 n=%0d got=%h exp=%h", n, obs, exp_all());
                end
                total++;
            end
        end
        if ({h_mt, h_mo, h_st, h_so, h_run} !== {4'd0, 4'd1, 4'd1, 4'd5, 1'b1}) begin
            bad++; $display("FAIL count75_final got=%h exp=%h", {h_mt, h_mo, h_st, h_so, h_run},
                            {4'd0, 4'd1, 4'd1, 4'd5, 1'b1});
        end
        total++;
    endtask

    task automatic test_tick_edge();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (9) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        if ({h_mt, h_mo, h_st, h_so, h_run} !== {4'd0, 4'd0, 4'd1, 4'd0, 1'b0}) begin
            bad++; $display("FAIL tick_edge_pause got=%h exp=%h", {h_mt, h_mo, h_st, h_so, h_run},
                            {4'd0, 4'd0, 4'd1, 4'd0, 1'b0});
        end
        total++;
        step(1'b0, 1'b0, 1'b0);
        repeat (5) begin
            step(1'b1, 1'b0, 1'b0);
            if (obs !== exp_all()) begin
                bad++; $display("FAIL pause_frozen got=%h exp=%h", obs, exp_all());
            end
            total++;
        end
        step(1'b0, 1'b1, 1'b0);
        if ({h_mt, h_mo, h_st, h_so, h_run, w_run} !== {4'd0, 4'd0, 4'd1, 4'd0, 1'b1, 1'b1}) begin
            bad++; $display("FAIL resume got=%h exp=%h", {h_mt, h_mo, h_st, h_so, h_run, w_run},
                            {4'd0, 4'd0, 4'd1, 4'd0, 1'b1, 1'b1});
        end
        total++;
    endtask

    task automatic test_clear_priority();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (30) step(1'b1, 1'b0, 1'b0);
        if ({h_mt, h_mo, h_st, h_so, h_run} !== {4'd0, 4'd0, 4'd3, 4'd0, 1'b1}) begin
            bad++; $display("FAIL at_0030 got=%h exp=%h", {h_mt, h_mo, h_st, h_so, h_run},
                            {4'd0, 4'd0, 4'd3, 4'd0, 1'b1});
        end
        total++;
        step(1'b1, 1'b1, 1'b1);
        if (obs !== 38'd0) begin
            bad++; $display("FAIL clear_priority got=%h exp=%h", obs, 38'd0);
        end
        total++;
        step(1'b1, 1'b1, 1'b0);
        if (obs !== exp_all()) begin
            bad++; $display("FAIL clear_then_idle got=%h exp=%h", obs, exp_all());
        end
        total++;
    endtask

    task automatic test_hold_wrap();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3598; n++) begin
            step(1'b1, 1'b0, 1'b0);
            if (obs !== exp_all()) begin
                bad++; $display("FAIL long_count n=%0d got=%h exp=%h", n, obs, exp_all());
            end
            total++;
        end
        for (int n = 0; n < 3; n++) begin
            step(1'b1, 1'b0, 1'b0);
            if (obs !== exp_all()) begin
                bad++; $display("FAIL at_max n=%0d got=%h exp=%h", n, obs, exp_all());
            end
            total++;
            if (n == 1 && {w_mt, w_mo, w_st, w_so, w_run, w_wrap} !== {16'h0000, 1'b1, 1'b1}) begin
                bad++; $display("FAIL wrap_pulse got=%h exp=%h", {w_mt, w_mo, w_st, w_so, w_run, w_wrap},
                                {16'h0000, 1'b1, 1'b1});
            end
            if (n == 1) total++;
        end
        if ({h_mt, h_mo, h_st, h_so, h_done, h_run, h_wrap} !== {16'h5959, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL hold_done got=%h exp=%h", {h_mt, h_mo, h_st, h_so, h_done, h_run, h_wrap},
                            {16'h5959, 1'b1, 1'b0, 1'b0});
        end
        total++;
        if ({w_mt, w_mo, w_st, w_so, w_wrap} !== {16'h0001, 1'b0}) begin
            bad++; $display("FAIL wrap_after got=%h exp=%h", {w_mt, w_mo, w_st, w_so, w_wrap}, {16'h0001, 1'b0});
        end
        total++;
        step(1'b1, 1'b1, 1'b0);
        if ({h_mt, h_mo, h_st, h_so, h_done, h_run} !== {16'h5959, 1'b1, 1'b0}) begin
            bad++; $display("FAIL done_ignores_edge got=%h exp=%h", {h_mt, h_mo, h_st, h_so, h_done, h_run},
                            {16'h5959, 1'b1, 1'b0});
        end
        total++;
        step(1'b0, 1'b0, 1'b1);
        if (obs !== 38'd0) begin
            bad++; $display("FAIL done_clear got=%h exp=%h", obs, 38'd0);
        end
        total++;
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (42) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        if (obs !== exp_all()) begin
            bad++; $display("FAIL at_0042 got=%h exp=%h", obs, exp_all());
        end
        total++;
        reset_n = 1'b0;
        model_reset();
        #1;
        if (obs !== 38'd0) begin
            bad++; $display("FAIL async_reset got=%h exp=%h", obs, 38'd0);
        end
        total++;
        #1;
        reset_n = 1'b1;
        repeat (3) begin
            step(1'b1, 1'b1, 1'b0);
            if (obs !== 38'd0) begin
                bad++; $display("FAIL held_button got=%h exp=%h", obs, 38'd0);
            end
            total++;
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        if ({h_run, w_run} !== 2'b11) begin
            bad++; $display("FAIL restart got=%b exp=%b", {h_run, w_run}, 2'b11);
        end
        total++;
    endtask

    task automatic test_random();
        bit ss;
        bit tk;
        bit clr;
        ss = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) ss = !ss;
            tk  = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 199) == 0);
            step(tk, ss, clr);
            if (obs !== exp_all()) begin
                bad++; $display("FAIL random n=%0d got=%h exp=%h", n, obs, exp_all());
            end
            total++;
        end
    endtask

    initial begin
        test_reset();
        test_count_75();
        test_tick_edge();
        test_clear_priority();
        test_hold_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
